// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the load/store pipeline stages and the MEM-stage state type.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Non-memory opcodes that architecturally produce a register result.
    function automatic logic writes_rd(input logic [6:0] op);
        logic w;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: w = 1'b1;
            default:                                         w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] lane_s;

    assign lane_s = ld_word >> {ld_off, 3'b000};

    // Store data is replicated into every lane so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_funct3)
            F3_B: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load result from the addressed lane, extended according to funct3.
    always_comb begin
        ld_data = lane_s;
        case (ld_funct3)
            F3_B:    ld_data = {{24{lane_s[7]}}, lane_s[7:0]};
            F3_H:    ld_data = {{16{lane_s[15]}}, lane_s[15:0]};
            F3_BU:   ld_data = {24'h000000, lane_s[7:0]};
            F3_HU:   ld_data = {16'h0000, lane_s[15:0]};
            default: ld_data = lane_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: MEM/WB register, req/ack data-memory handshake with watchdog, upstream stall.
module mem_stage
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] c,
    input  logic [31:0] data2,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_out,
    output logic        reg_we,
    output logic [4:0]  rd_out,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r, we_r;
    logic [31:0]       addr_r, wdata_r, wb_data_r;
    logic [3:0]        be_r;
    logic [2:0]        f3_r;
    logic [1:0]        off_r;
    logic              valid_out_r, reg_we_r, mis_r, ill_r, berr_r;
    logic [4:0]        rd_out_r;

    logic              is_load_s, is_store_s, is_mem_s, ill_s, mis_s, expire_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, ld_data_s;

    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign is_mem_s   = is_load_s | is_store_s;
    assign ill_s      = is_mem_s & ~f3_legal(is_store_s, funct3);
    assign mis_s      = is_mem_s & ~ill_s & f3_misaligned(funct3, c[1:0]);
    assign expire_s   = (TIMEOUT != 0) && (cnt_r == TMO_LAST);

    mem_align u_align (
        .st_funct3 (funct3),
        .st_off    (c[1:0]),
        .st_data   (data2),
        .ld_funct3 (f3_r),
        .ld_off    (off_r),
        .ld_word   (dmem_rdata),
        .be        (be_s),
        .wdata     (wdata_s),
        .ld_data   (ld_data_s)
    );

    // Transaction FSM and MEM/WB register; rd_out holds the latched rd throughout BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            be_r        <= 4'b0000;
            wdata_r     <= 32'h0000_0000;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            valid_out_r <= 1'b0;
            reg_we_r    <= 1'b0;
            rd_out_r    <= 5'd0;
            wb_data_r   <= 32'h0000_0000;
            mis_r       <= 1'b0;
            ill_r       <= 1'b0;
            berr_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r       <= '0;
                    valid_out_r <= 1'b0;
                    reg_we_r    <= 1'b0;
                    mis_r       <= 1'b0;
                    ill_r       <= 1'b0;
                    berr_r      <= 1'b0;
                    if (valid_in) begin
                        rd_out_r  <= rd;
                        wb_data_r <= c;
                        if (is_mem_s && !ill_s && !mis_s) begin
                            state_r <= BUSY;
                            req_r   <= 1'b1;
                            we_r    <= is_store_s;
                            addr_r  <= {c[31:2], 2'b00};
                            be_r    <= is_store_s ? be_s : 4'b1111;
                            wdata_r <= is_store_s ? wdata_s : 32'h0000_0000;
                            f3_r    <= funct3;
                            off_r   <= c[1:0];
                        end else begin
                            valid_out_r <= 1'b1;
                            reg_we_r    <= ~is_mem_s & writes_rd(opcode) & (rd != 5'd0);
                            mis_r       <= mis_s;
                            ill_r       <= ill_s;
                        end
                    end else begin
                        wb_data_r <= wb_data_r;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state_r     <= IDLE;
                        req_r       <= 1'b0;
                        valid_out_r <= 1'b1;
                        reg_we_r    <= ~we_r & (rd_out_r != 5'd0);
                        wb_data_r   <= ld_data_s;
                    end else if (expire_s) begin
                        state_r     <= IDLE;
                        req_r       <= 1'b0;
                        valid_out_r <= 1'b1;
                        reg_we_r    <= 1'b0;
                        berr_r      <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_out  = (state_r == BUSY);
    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;
    assign valid_out  = valid_out_r;
    assign reg_we     = reg_we_r;
    assign rd_out     = rd_out_r;
    assign wb_data    = wb_data_r;
    assign misaligned = mis_r;
    assign illegal    = ill_r;
    assign bus_err    = berr_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model, scoreboard queue and directed vectors.
module tb_mem_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] c = 32'd0, data2 = 32'd0;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;
    logic        valid_out, reg_we, misaligned, illegal, bus_err;
    logic [4:0]  rd_out;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .funct3(funct3),
        .rd(rd), .c(c), .data2(data2), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_out(valid_out), .reg_we(reg_we),
        .rd_out(rd_out), .wb_data(wb_data), .misaligned(misaligned), .illegal(illegal),
        .bus_err(bus_err)
    );

    typedef struct packed {
        logic        mem_req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  rd;
        logic        reg_we;
        logic        chk_wb;
        logic [31:0] wb;
        logic        mis, ill, berr;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    int ack_cycle = 0, busy_n = 0;
    logic [31:0] ack_rdata = 32'd0;
    bit spur = 1'b0;
    int stall_cnt = 0, req_cnt = 0, retire_cnt = 0, berr_cnt = 0;
    logic [31:0] last_wb = 32'd0, last_addr = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_be = 4'd0;
    logic        last_we = 1'b0, last_reg_we = 1'b0, last_mis = 1'b0, last_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected retirement and request derived from the ISA rules with plain arithmetic.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                   input logic [31:0] cc, input logic [31:0] d2,
                                   input logic [31:0] rdata, input bit tmo);
        exp_t e;
        int size, off;
        bit sgn, legal, store;
        logic [63:0] v, mask;
        e = '0;
        e.rd = r;
        off = int'(cc % 32'd4);
        size = 4;
        sgn = 1'b0;
        legal = 1'b1;
        if (op == 7'h03 || op == 7'h23) begin
            store = (op == 7'h23);
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 1'b0;
            endcase
            if (store && f3 > 3'd2) legal = 1'b0;
            if (!legal) e.ill = 1'b1;
            else if (off % size != 0) e.mis = 1'b1;
            else begin
                e.mem_req = 1'b1;
                e.addr = cc - 32'(off);
                e.we = store;
                if (store) begin
                    e.be = 4'(((1 << size) - 1) << off);
                    if (size == 1) e.wdata = {24'h0, d2[7:0]} * 32'h0101_0101;
                    else if (size == 2) e.wdata = {16'h0, d2[15:0]} * 32'h0001_0001;
                    else e.wdata = d2;
                end else begin
                    e.be = 4'hF;
                    mask = (64'd1 << (8 * size)) - 64'd1;
                    v = ({32'h0, rdata} >> (8 * off)) & mask;
                    if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
                    e.wb = v[31:0];
                    e.chk_wb = 1'b1;
                    e.reg_we = (r != 5'd0);
                end
                if (tmo) begin
                    e.berr = 1'b1;
                    e.reg_we = 1'b0;
                    e.chk_wb = 1'b0;
                end
            end
        end else begin
            e.wb = cc;
            e.chk_wb = 1'b1;
            e.reg_we = (r != 5'd0) && (op == 7'h37 || op == 7'h17 || op == 7'h6F ||
                                       op == 7'h67 || op == 7'h13 || op == 7'h33);
        end
        return e;
    endfunction

    // Memory responder: ack in the ack_cycle-th request cycle (0 = never).
    initial forever begin
        @(negedge clk);
        if (dmem_req) begin
            busy_n++;
            if (ack_cycle != 0 && busy_n == ack_cycle) begin
                dmem_ack = 1'b1;
                dmem_rdata = ack_rdata;
            end else begin
                dmem_ack = 1'b0;
                dmem_rdata = 32'd0;
            end
        end else begin
            busy_n = 0;
            dmem_ack = spur;
            dmem_rdata = spur ? 32'hFFFF_FFFF : 32'd0;
        end
    end

    // Per-cycle compare against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("stall_vs_req", {31'd0, stall_out}, {31'd0, dmem_req});
        if (stall_out) stall_cnt++;
        if (dmem_req) begin
            req_cnt++;
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
            if (q.size() == 0) chk("req_without_instr", 32'd1, 32'd0);
            else begin
                e = q[0];
                chk("req_expected", {31'd0, e.mem_req}, 32'd1);
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
                if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
            end
        end
        if (!valid_out) begin
            chk("bubble_flags", {28'd0, reg_we, misaligned, illegal, bus_err}, 32'd0);
        end else if (q.size() == 0) begin
            chk("unexpected_retire", {31'd0, valid_out}, 32'd0);
        end else begin
            e = q.pop_front();
            retire_cnt++;
            if (bus_err) berr_cnt++;
            last_wb = wb_data; last_reg_we = reg_we; last_mis = misaligned; last_ill = illegal;
            chk("reg_we", {31'd0, reg_we}, {31'd0, e.reg_we});
            chk("flags", {29'd0, misaligned, illegal, bus_err}, {29'd0, e.mis, e.ill, e.berr});
            if (e.chk_wb) begin
                chk("wb_data", wb_data, e.wb);
                chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            end
        end
    end

    // Present an instruction at a negedge and hold it until the stage accepts it.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] cc, input logic [31:0] d2,
                         input logic [31:0] rdata, input bit tmo);
        int n;
        valid_in = 1'b1; opcode = op; funct3 = f3; rd = r; c = cc; data2 = d2;
        q.push_back(model(op, f3, r, cc, d2, rdata, tmo));
        n = 0;
        while (stall_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall_out) chk("issue_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic drain();
        valid_in = 1'b0;
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] cc, input logic [31:0] d2, input logic [31:0] rdata,
                       input int ack, input bit tmo);
        ack_cycle = ack;
        ack_rdata = rdata;
        issue(op, f3, r, cc, d2, rdata, tmo);
        drain();
    endtask

    initial begin
        int r0, b0;
        #3;
        chk("rst_outputs", {22'd0, valid_out, reg_we, misaligned, illegal, bus_err, stall_out,
                            dmem_req, dmem_we, dmem_be}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stall_cnt = 0;
        run(OP_IMM, 3'd0, 5'd5, 32'h6, 32'd0, 32'd0, 1, 1'b0);
        chk("t1_wb", last_wb, 32'h6);
        chk("t1_reg_we", {31'd0, last_reg_we}, 32'd1);
        chk("t1_no_stall", stall_cnt, 32'd0);

        stall_cnt = 0;
        run(OP_LOAD, F3_B, 5'd3, 32'h1003, 32'd0, 32'h80AA_BBCC, 3, 1'b0);
        chk("t2_addr", last_addr, 32'h1000);
        chk("t2_stall_cycles", stall_cnt, 32'd3);
        chk("t2_wb", last_wb, 32'hFFFF_FF80);
        chk("t2_reg_we", {31'd0, last_reg_we}, 32'd1);

        run(OP_STORE, F3_H, 5'd9, 32'h2002, 32'h1234_5678, 32'd0, 1, 1'b0);
        chk("t3_be", {28'd0, last_be}, 32'hC);
        chk("t3_wdata", last_wdata, 32'h5678_5678);
        chk("t3_we", {31'd0, last_we}, 32'd1);
        chk("t3_reg_we", {31'd0, last_reg_we}, 32'd0);

        req_cnt = 0;
        r0 = retire_cnt;
        run(OP_LOAD, F3_W, 5'd4, 32'h2001, 32'd0, 32'd0, 1, 1'b0);
        chk("t4_no_req", req_cnt, 32'd0);
        chk("t4_retired", retire_cnt - r0, 32'd1);
        chk("t4_mis", {31'd0, last_mis}, 32'd1);

        // Watchdog expiry, with the next instruction held upstream during the stall.
        req_cnt = 0;
        b0 = berr_cnt;
        ack_cycle = 0;
        issue(OP_LOAD, F3_W, 5'd6, 32'h3000, 32'd0, 32'd0, 1'b1);
        issue(OP_OP, 3'd0, 5'd7, 32'h77, 32'd0, 32'd0, 1'b0);
        drain();
        chk("t5_req_cycles", req_cnt, 32'd4);
        chk("t5_bus_err", berr_cnt - b0, 32'd1);
        chk("t5_next_wb", last_wb, 32'h77);

        ack_cycle = 0;
        issue(OP_LOAD, F3_W, 5'd8, 32'h4000, 32'd0, 32'd0, 1'b0);
        valid_in = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", {29'd0, dmem_req, valid_out, stall_out}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(OP_LOAD, F3_BU, 5'd2, 32'h5000, 32'd0, 32'h0000_00F0, 1, 1'b0);
        chk("t6_lbu", last_wb, 32'h0000_00F0);

        run(OP_LOAD, F3_H, 5'd10, 32'h1006, 32'd0, 32'h8001_0000, 2, 1'b0);
        chk("lh_wb", last_wb, 32'hFFFF_8001);
        run(OP_LOAD, F3_HU, 5'd11, 32'h1006, 32'd0, 32'h8001_0000, 1, 1'b0);
        chk("lhu_wb", last_wb, 32'h0000_8001);
        run(OP_LOAD, F3_W, 5'd12, 32'h100C, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        run(OP_STORE, F3_B, 5'd0, 32'h3001, 32'h0000_00AB, 32'd0, 1, 1'b0);
        chk("sb_be", {28'd0, last_be}, 32'h2);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        run(OP_STORE, F3_W, 5'd0, 32'h3004, 32'hCAFE_F00D, 32'd0, 2, 1'b0);
        run(OP_LOAD, 3'd3, 5'd13, 32'h1000, 32'd0, 32'd0, 1, 1'b0);
        chk("ld_illegal", {31'd0, last_ill}, 32'd1);
        run(OP_STORE, 3'd4, 5'd0, 32'h1000, 32'd0, 32'd0, 1, 1'b0);
        run(OP_LOAD, F3_H, 5'd14, 32'h1001, 32'd0, 32'd0, 1, 1'b0);
        run(OP_BRANCH, 3'd0, 5'd5, 32'h40, 32'd0, 32'd0, 1, 1'b0);
        run(OP_LUI, 3'd0, 5'd0, 32'h1234_5000, 32'd0, 32'd0, 1, 1'b0);
        run(OP_JAL, 3'd0, 5'd1, 32'h104, 32'd0, 32'd0, 1, 1'b0);
        b0 = berr_cnt;
        run(OP_LOAD, F3_W, 5'd15, 32'h2000, 32'd0, 32'h1234_5678, 4, 1'b0);
        chk("ack_at_expiry_wb", last_wb, 32'h1234_5678);
        chk("ack_at_expiry_no_berr", berr_cnt - b0, 32'd0);

        r0 = retire_cnt;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spurious_ack", retire_cnt - r0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
